// File: rtl/rle_pkg.sv
// Shared definitions for the two-requester run-length encoder.
// Holds the default maximum run length, the controller state type and the
// packed token layout that is presented on the m_* output port.
package rle_pkg;

    // Longest run a single token may describe; longer runs are split.
    localparam logic [7:0] MAX_RUN_DEFAULT = 8'd255;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // One encoded token: byte value, run length, owning requester, end-of-packet.
    typedef struct packed {
        logic [7:0] data;
        logic [7:0] count;
        logic       src;
        logic       last;
    } token_t;

endpackage

// File: rtl/rle_run_acc.sv
// Run accumulator arithmetic for the RLE encoder.
// Decides whether an incoming byte extends the current run and produces the
// incremented count, saturating so the 8-bit count can never wrap.
// Ports:
//   run_data_i  current run byte value
//   run_cnt_i   current run length
//   byte_i      candidate byte
//   merge_o     1 when byte_i extends the run without exceeding MAX_RUN
//   cnt_inc_o   run_cnt_i + 1, saturated at 8'hFF
module rle_run_acc
    import rle_pkg::*;
#(
    parameter logic [7:0] MAX_RUN = MAX_RUN_DEFAULT
) (
    input  logic [7:0] run_data_i,
    input  logic [7:0] run_cnt_i,
    input  logic [7:0] byte_i,
    output logic       merge_o,
    output logic [7:0] cnt_inc_o
);

    // Merge test and saturating increment.
    always_comb begin
        merge_o = (byte_i == run_data_i) && (run_cnt_i < MAX_RUN);
        if (run_cnt_i == 8'hFF) begin
            cnt_inc_o = 8'hFF;
        end else begin
            cnt_inc_o = run_cnt_i + 8'd1;
        end
    end

endmodule

// File: rtl/rle_enc_arbiter.sv
// Two-requester run-length encoder with packet-level round-robin arbitration.
// A granted requester streams bytes; equal consecutive bytes are merged into
// (data, count) tokens. The grant is held for a whole packet, and the
// round-robin pointer only moves once a packet's final token is issued.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   s0_valid/s0_data/s0_last/s0_ready requester 0 byte stream
//   s1_valid/s1_data/s1_last/s1_ready requester 1 byte stream
//   m_valid/m_data/m_count/m_src/m_last/m_ready  token output stream
//   busy                              high whenever the controller is not idle
module rle_enc_arbiter
    import rle_pkg::*;
#(
    parameter logic [7:0] MAX_RUN = MAX_RUN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic [7:0] m_count,
    output logic       m_src,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy
);

    state_e     state_q, state_d;
    logic       grant_q, grant_d;     // requester owning the current packet
    logic       rr_q, rr_d;           // requester preferred when both are valid
    logic       first_q, first_d;     // no byte of the packet accepted yet
    logic [7:0] run_data_q, run_data_d;
    logic [7:0] run_cnt_q, run_cnt_d;
    token_t     tok_q;
    logic       m_valid_q;

    logic       emit_s;
    token_t     tok_s;
    logic       g_valid_s;
    logic [7:0] g_data_s;
    logic       g_last_s;
    logic       slot_free_s;
    logic       merge_s;
    logic [7:0] cnt_inc_s;

    rle_run_acc #(
        .MAX_RUN (MAX_RUN)
    ) u_run_acc (
        .run_data_i (run_data_q),
        .run_cnt_i  (run_cnt_q),
        .byte_i     (g_data_s),
        .merge_o    (merge_s),
        .cnt_inc_o  (cnt_inc_s)
    );

    // Mux the granted requester's stream; other input is ignored entirely.
    always_comb begin
        if (grant_q) begin
            g_valid_s = s1_valid;
            g_data_s  = s1_data;
            g_last_s  = s1_last;
        end else begin
            g_valid_s = s0_valid;
            g_data_s  = s0_data;
            g_last_s  = s0_last;
        end
        // The output register can take a new token if empty or draining now.
        slot_free_s = !m_valid_q || m_ready;
    end

    // Next-state, run update, ready and token-emission logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        first_d    = first_q;
        run_data_d = run_data_q;
        run_cnt_d  = run_cnt_q;
        emit_s     = 1'b0;
        tok_s      = '0;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    // Both valid: take the pointer's choice; else the lone one.
                    grant_d = (s0_valid && s1_valid) ? rr_q : s1_valid;
                    first_d = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (slot_free_s) begin
                    s0_ready = !grant_q;
                    s1_ready = grant_q;
                end else begin
                    s0_ready = 1'b0;
                    s1_ready = 1'b0;
                end

                if (g_valid_s && slot_free_s) begin
                    tok_s.src = grant_q;
                    if (first_q) begin
                        first_d    = 1'b0;
                        run_data_d = g_data_s;
                        run_cnt_d  = 8'd1;
                        if (g_last_s) begin
                            emit_s      = 1'b1;
                            tok_s.data  = g_data_s;
                            tok_s.count = 8'd1;
                            tok_s.last  = 1'b1;
                            rr_d        = !grant_q;
                            state_d     = ST_IDLE;
                        end else begin
                            emit_s = 1'b0;
                        end
                    end else if (merge_s) begin
                        run_cnt_d = cnt_inc_s;
                        if (g_last_s) begin
                            emit_s      = 1'b1;
                            tok_s.data  = run_data_q;
                            tok_s.count = cnt_inc_s;
                            tok_s.last  = 1'b1;
                            rr_d        = !grant_q;
                            state_d     = ST_IDLE;
                        end else begin
                            emit_s = 1'b0;
                        end
                    end else begin
                        // Differing byte or saturated run: close the old run.
                        emit_s      = 1'b1;
                        tok_s.data  = run_data_q;
                        tok_s.count = run_cnt_q;
                        tok_s.last  = 1'b0;
                        run_data_d  = g_data_s;
                        run_cnt_d   = 8'd1;
                        if (g_last_s) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (slot_free_s) begin
                    emit_s      = 1'b1;
                    tok_s.data  = run_data_q;
                    tok_s.count = run_cnt_q;
                    tok_s.src   = grant_q;
                    tok_s.last  = 1'b1;
                    rr_d        = !grant_q;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller, arbitration and run state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            rr_q       <= 1'b0;
            first_q    <= 1'b0;
            run_data_q <= 8'd0;
            run_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            first_q    <= first_d;
            run_data_q <= run_data_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    // Output token register: load on emit, hold while stalled, clear on drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok_q     <= '0;
            m_valid_q <= 1'b0;
        end else if (emit_s) begin
            tok_q     <= tok_s;
            m_valid_q <= 1'b1;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_q;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = tok_q.data;
    assign m_count = tok_q.count;
    assign m_src   = tok_q.src;
    assign m_last  = tok_q.last;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rle_enc_arbiter.sv
// Directed self-checking bench for rle_enc_arbiter.
module tb_rle_enc_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       s0_valid, s0_last, s0_ready;
    logic [7:0] s0_data;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] s1_data;
    logic       m_valid, m_src, m_last, m_ready;
    logic [7:0] m_data, m_count;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int t;

    logic [17:0] tokq[$];

    rle_enc_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_count  (m_count),
        .m_src    (m_src),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Log every token handshake as {data, count, src, last}.
    always @(posedge clk) begin
        if (rst && m_valid && m_ready) begin
            tokq.push_back({m_data, m_count, m_src, m_last});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send n bytes from a requester; byte i is bv[8*i+:8] for i<4, else fill.
    // Entered and left at a falling clock edge.
    task automatic send_pkt(input logic src, input int n, input logic [31:0] bv,
                            input logic [7:0] fill, input logic do_last);
        logic       rdy;
        logic [7:0] b;
        int         w;
        for (int i = 0; i < n; i++) begin
            b = (i < 4) ? bv[8*i +: 8] : fill;
            if (src) begin
                s1_valid = 1'b1; s1_data = b; s1_last = do_last && (i == n - 1);
            end else begin
                s0_valid = 1'b1; s0_data = b; s0_last = do_last && (i == n - 1);
            end
            w = 0;
            do begin
                #1;
                rdy = src ? s1_ready : s0_ready;
                @(posedge clk);
                @(negedge clk);
                w++;
            end while (!rdy && w < 100);
            chk(src ? "s1_accept" : "s0_accept", {31'd0, rdy}, 32'd1);
        end
        if (src) begin
            s1_valid = 1'b0; s1_last = 1'b0;
        end else begin
            s0_valid = 1'b0; s0_last = 1'b0;
        end
    endtask

    task automatic expect_tok(input string tag, input logic [7:0] d, input logic [7:0] c,
                              input logic s, input logic l);
        int w;
        logic [17:0] got;
        w = 0;
        while (tokq.size() == 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_present"}, {31'd0, tokq.size() != 0}, 32'd1);
        if (tokq.size() != 0) begin
            got = tokq.pop_front();
            chk(tag, {14'd0, got}, {14'd0, d, c, s, l});
        end
    endtask

    initial begin
        rst = 1'b0;
        s0_valid = 1'b0; s0_data = 8'd0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = 8'd0; s1_last = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data",  {24'd0, m_data},  32'd0);
        chk("rst_m_count", {24'd0, m_count}, 32'd0);
        chk("rst_m_src",   {31'd0, m_src},   32'd0);
        chk("rst_m_last",  {31'd0, m_last},  32'd0);
        chk("rst_ready",   {30'd0, s0_ready, s1_ready}, 32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Round robin: both valid after reset, twice
        for (int r = 0; r < 2; r++) begin
            fork
                send_pkt(1'b0, 1, 32'h0000_0010, 8'h00, 1'b1);
                send_pkt(1'b1, 1, 32'h0000_0020, 8'h00, 1'b1);
            join
            expect_tok("rr_first_s0",  8'h10, 8'd1, 1'b0, 1'b1);
            expect_tok("rr_second_s1", 8'h20, 8'd1, 1'b1, 1'b1);
        end

        // AA,AA,AA(last) -> one merged token
        send_pkt(1'b0, 3, 32'h00AA_AAAA, 8'h00, 1'b1);
        expect_tok("aa_run", 8'hAA, 8'd3, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("aa_busy_low", {31'd0, busy}, 32'd0);

        // s1: 11,22,22(last)
        send_pkt(1'b1, 3, 32'h0022_2211, 8'h00, 1'b1);
        expect_tok("s1_tok0", 8'h11, 8'd1, 1'b1, 1'b0);
        expect_tok("s1_tok1", 8'h22, 8'd2, 1'b1, 1'b1);

        // 300 x 5A -> saturated split
        send_pkt(1'b0, 300, 32'h5A5A_5A5A, 8'h5A, 1'b1);
        expect_tok("sat_tok0", 8'h5A, 8'd255, 1'b0, 1'b0);
        expect_tok("sat_tok1", 8'h5A, 8'd45,  1'b0, 1'b1);

        // Output stall mid-packet; last byte differs so FLUSH is exercised
        m_ready = 1'b0;
        fork
            send_pkt(1'b0, 4, 32'h0403_0201, 8'h00, 1'b1);
            begin
                t = 0;
                while (!m_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("stall_valid_seen", {31'd0, m_valid}, 32'd1);
                for (int k = 0; k < 4; k++) begin
                    chk("stall_m_tok", {14'd0, m_data, m_count, m_src, m_last},
                        {14'd0, 8'h01, 8'd1, 1'b0, 1'b0});
                    chk("stall_ready", {31'd0, s0_ready}, 32'd0);
                    @(negedge clk);
                end
                chk("stall_no_handshake", tokq.size(), 32'd0);
                m_ready = 1'b1;
            end
        join
        expect_tok("stall_tok0", 8'h01, 8'd1, 1'b0, 1'b0);
        expect_tok("stall_tok1", 8'h02, 8'd1, 1'b0, 1'b0);
        expect_tok("stall_tok2", 8'h03, 8'd1, 1'b0, 1'b0);
        expect_tok("stall_tok3", 8'h04, 8'd1, 1'b0, 1'b1);

        // Reset mid-run with count 7
        send_pkt(1'b0, 7, 32'h3333_3333, 8'h33, 1'b0);
        @(negedge clk);
        chk("midrun_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_m_tok", {14'd0, m_data, m_count, m_src, m_last}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {30'd0, s0_ready, s1_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_token", tokq.size(), 32'd0);
        send_pkt(1'b0, 1, 32'h0000_0033, 8'h00, 1'b1);
        expect_tok("post_rst_tok", 8'h33, 8'd1, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", tokq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
